// File: rtl/busarb2.sv
// busarb2: two-master system bus arbiter that never switches masters mid-transaction
// Ports: clk, reset (sync, active-high);
//        m0_*/m1_* master sides: en/wr/size/addr/data_out in, data_in/wt out;
//        bus_* slave side: en/wr/size/addr/data_out out, data_in/wt in;
//        owner: master currently selected onto the bus.
// Arbitration: fixed priority to master 1 by default; define BUSARB_ROUNDROBIN_EN
//        to give conflicts to the master that did not complete most recently.
module busarb2 #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_en,
    input  logic          m0_wr,
    input  logic [1:0]    m0_size,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_data_out,
    output logic [DW-1:0] m0_data_in,
    output logic          m0_wt,
    input  logic          m1_en,
    input  logic          m1_wr,
    input  logic [1:0]    m1_size,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_data_out,
    output logic [DW-1:0] m1_data_in,
    output logic          m1_wt,
    output logic          bus_en,
    output logic          bus_wr,
    output logic [1:0]    bus_size,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_data_out,
    input  logic [DW-1:0] bus_data_in,
    input  logic          bus_wt,
    output logic          owner
);
    logic locked_q, owner_q, last_q;
    logic locked_d, owner_d, last_d;
    logic win, sel, sel_en;
`ifdef BUSARB_ROUNDROBIN_EN
    assign win = ~last_q;
`else
    assign win = 1'b1;
`endif
    always_comb begin
        sel = locked_q ? owner_q : (m0_en & m1_en) ? win : m1_en ? 1'b1 : m0_en ? 1'b0 : owner_q;
        sel_en = sel ? m1_en : m0_en;
        // an owner dropping en while locked lands here with sel_en=0 and releases the lock
        locked_d = sel_en & bus_wt;
        owner_d = sel_en ? sel : owner_q;
        last_d = (sel_en & ~bus_wt) ? sel : last_q;
    end
    assign bus_en       = sel_en;
    assign bus_wr       = sel ? m1_wr : m0_wr;
    assign bus_size     = sel ? m1_size : m0_size;
    assign bus_addr     = sel ? m1_addr : m0_addr;
    assign bus_data_out = sel ? m1_data_out : m0_data_out;
    assign m0_data_in   = bus_data_in;
    assign m1_data_in   = bus_data_in;
    // the master not on the bus is held off for as long as it requests
    assign m0_wt        = sel ? m0_en : bus_wt;
    assign m1_wt        = sel ? bus_wt : m1_en;
    assign owner        = sel;
    always_ff @(posedge clk) begin
        if (reset) begin
            locked_q <= 1'b0;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
        end else begin
            locked_q <= locked_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
        end
    end
endmodule

// File: tb/tb_busarb2.sv
// tb_busarb2: directed and randomized checks of busarb2 against a rule-level model
module tb_busarb2;
    localparam int AW = 32;
    localparam int DW = 32;
    logic          clk = 1'b0;
    logic          reset;
    logic          m0_en, m0_wr, m1_en, m1_wr;
    logic [1:0]    m0_size, m1_size;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_data_out, m1_data_out, m0_data_in, m1_data_in;
    logic          m0_wt, m1_wt;
    logic          bus_en, bus_wr, bus_wt, owner;
    logic [1:0]    bus_size;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_data_out, bus_data_in;
    int vectors = 0;
    int miscompares = 0;
    logic r_locked, r_owner, r_last;

    always #5 clk = ~clk;

    busarb2 #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset),
        .m0_en(m0_en), .m0_wr(m0_wr), .m0_size(m0_size), .m0_addr(m0_addr),
        .m0_data_out(m0_data_out), .m0_data_in(m0_data_in), .m0_wt(m0_wt),
        .m1_en(m1_en), .m1_wr(m1_wr), .m1_size(m1_size), .m1_addr(m1_addr),
        .m1_data_out(m1_data_out), .m1_data_in(m1_data_in), .m1_wt(m1_wt),
        .bus_en(bus_en), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
        .bus_data_out(bus_data_out), .bus_data_in(bus_data_in), .bus_wt(bus_wt),
        .owner(owner)
    );

    function automatic logic ref_sel();
        if (r_locked) return r_owner;
        if (m0_en && m1_en) begin
`ifdef BUSARB_ROUNDROBIN_EN
            return (r_last == 1'b0) ? 1'b1 : 1'b0;
`else
            return 1'b1;
`endif
        end
        if (m1_en) return 1'b1;
        if (m0_en) return 1'b0;
        return r_owner;
    endfunction

    task automatic tick();
        logic s, en;
        s = ref_sel();
        en = s ? m1_en : m0_en;
        @(posedge clk);
        if (reset) begin
            r_locked = 1'b0; r_owner = 1'b0; r_last = 1'b1;
        end else if (en && bus_wt) begin
            r_locked = 1'b1; r_owner = s;
        end else if (en) begin
            r_locked = 1'b0; r_owner = s; r_last = s;
        end else begin
            r_locked = 1'b0;
        end
        #1;
    endtask

    task automatic idle();
        m0_en = 0; m0_wr = 0; m0_size = 0; m0_addr = 0; m0_data_out = 0;
        m1_en = 0; m1_wr = 0; m1_size = 0; m1_addr = 0; m1_data_out = 0;
        bus_wt = 0; bus_data_in = 0;
    endtask

    task automatic do_reset();
        reset = 1; idle(); tick(); reset = 0;
    endtask

    task automatic test_reset();
        reset = 1; idle(); tick(); tick(); reset = 0;
        #3;
        vectors++; if (bus_en !== 1'b0) begin miscompares++; $display("FAIL reset_bus_en got %b want 0", bus_en); end
        vectors++; if ({m0_wt, m1_wt} !== 2'b00) begin miscompares++; $display("FAIL reset_wt got %b%b want 00", m0_wt, m1_wt); end
        vectors++; if (owner !== 1'b0) begin miscompares++; $display("FAIL reset_owner got %b want 0", owner); end
        tick();
    endtask

    task automatic test_single();
        m0_en = 1; m0_wr = 0; m0_addr = 32'h0000_0100; bus_wt = 0; bus_data_in = 32'h1234_5678;
        #3;
        vectors++; if (bus_en !== 1'b1 || bus_addr !== 32'h100) begin miscompares++; $display("FAIL single_fwd got en=%b addr=%h want en=1 addr=00000100", bus_en, bus_addr); end
        vectors++; if (m0_wt !== 1'b0 || m1_wt !== 1'b0) begin miscompares++; $display("FAIL single_wt got %b%b want 00", m0_wt, m1_wt); end
        vectors++; if (m0_data_in !== 32'h1234_5678) begin miscompares++; $display("FAIL single_rdata got %h want 12345678", m0_data_in); end
        tick();
        idle();
    endtask

    task automatic test_lock_hold();
        m0_en = 1; m0_wr = 1; m0_addr = 32'h200; m0_data_out = 32'hDEAD_BEEF; m1_addr = 32'h300;
        for (int c = 1; c <= 4; c++) begin
            bus_wt = (c < 4); m1_en = (c >= 2);
            #3;
            vectors++; if (bus_en !== 1'b1 || bus_addr !== 32'h200 || bus_wr !== 1'b1) begin miscompares++; $display("FAIL lock_fwd cycle %0d got en=%b addr=%h wr=%b want en=1 addr=00000200 wr=1", c, bus_en, bus_addr, bus_wr); end
            vectors++; if (m1_wt !== (c >= 2)) begin miscompares++; $display("FAIL lock_m1_wt cycle %0d got %b want %b", c, m1_wt, c >= 2); end
            vectors++; if (m0_wt !== (c < 4)) begin miscompares++; $display("FAIL lock_m0_wt cycle %0d got %b want %b", c, m0_wt, c < 4); end
            tick();
        end
        m0_en = 0; bus_wt = 0;
        #3;
        vectors++; if (bus_en !== 1'b1 || bus_addr !== 32'h300 || owner !== 1'b1 || m1_wt !== 1'b0) begin miscompares++; $display("FAIL lock_handover got en=%b addr=%h owner=%b m1_wt=%b want 1 00000300 1 0", bus_en, bus_addr, owner, m1_wt); end
        tick();
        idle();
    endtask

    task automatic test_conflict();
        logic [3:0] exp;
`ifdef BUSARB_ROUNDROBIN_EN
        exp = 4'b1010;
`else
        exp = 4'b1111;
`endif
        do_reset();
        m0_en = 1; m1_en = 1; m0_addr = 32'h1000; m1_addr = 32'h2000; bus_wt = 0;
        for (int c = 0; c < 4; c++) begin
            #3;
            vectors++; if (owner !== exp[c]) begin miscompares++; $display("FAIL conflict_owner cycle %0d got %b want %b", c, owner, exp[c]); end
            vectors++; if (m0_wt !== exp[c]) begin miscompares++; $display("FAIL conflict_m0_wt cycle %0d got %b want %b", c, m0_wt, exp[c]); end
            vectors++; if (bus_addr !== (exp[c] ? 32'h2000 : 32'h1000)) begin miscompares++; $display("FAIL conflict_addr cycle %0d got %h", c, bus_addr); end
            tick();
        end
        idle();
    endtask

    task automatic test_drop();
        do_reset();
        m0_en = 1; m0_addr = 32'h40; m1_addr = 32'h80; bus_wt = 1;
        tick();
        m0_en = 0; m1_en = 1;
        #3;
        vectors++; if (bus_en !== 1'b0 || owner !== 1'b0 || m1_wt !== 1'b1) begin miscompares++; $display("FAIL drop_cycle got en=%b owner=%b m1_wt=%b want 0 0 1", bus_en, owner, m1_wt); end
        tick();
        bus_wt = 0;
        #3;
        vectors++; if (bus_en !== 1'b1 || owner !== 1'b1 || bus_addr !== 32'h80 || m1_wt !== 1'b0) begin miscompares++; $display("FAIL drop_grant got en=%b owner=%b addr=%h m1_wt=%b want 1 1 00000080 0", bus_en, owner, bus_addr, m1_wt); end
        tick();
        idle();
    endtask

    task automatic test_reset_mid();
        do_reset();
        m1_en = 1; m1_addr = 32'h500; bus_wt = 1;
        tick();
        #3;
        vectors++; if (owner !== 1'b1 || m1_wt !== 1'b1) begin miscompares++; $display("FAIL rstmid_locked got owner=%b m1_wt=%b want 1 1", owner, m1_wt); end
        reset = 1;
        tick();
        reset = 0; idle();
        #3;
        vectors++; if (bus_en !== 1'b0 || m0_wt !== 1'b0 || m1_wt !== 1'b0 || owner !== 1'b0) begin miscompares++; $display("FAIL rstmid_idle got en=%b wt=%b%b owner=%b want 0 00 0", bus_en, m0_wt, m1_wt, owner); end
        m0_en = 1; m0_addr = 32'h600;
        #1;
        vectors++; if (bus_en !== 1'b1 || owner !== 1'b0 || m0_wt !== 1'b0 || bus_addr !== 32'h600) begin miscompares++; $display("FAIL rstmid_unlocked got en=%b owner=%b m0_wt=%b addr=%h want 1 0 0 00000600", bus_en, owner, m0_wt, bus_addr); end
        tick();
        idle();
    endtask

    task automatic test_wdata_routing();
        do_reset();
        m0_data_out = 32'hAAAA_5555; m1_data_out = 32'h0F0F_0F0F;
        m0_wr = 1; m0_size = 2; m1_wr = 0; m1_size = 1;
        for (int c = 0; c < 6; c++) begin
            m0_en = (c % 2 == 0); m1_en = (c % 2 == 1);
            #3;
            vectors++; if (bus_data_out !== ((c % 2 == 1) ? 32'h0F0F_0F0F : 32'hAAAA_5555) || owner !== (c % 2 == 1)) begin miscompares++; $display("FAIL wdata cycle %0d got data=%h owner=%b", c, bus_data_out, owner); end
            vectors++; if ({bus_wr, bus_size} !== ((c % 2 == 1) ? 3'b001 : 3'b110)) begin miscompares++; $display("FAIL wdata_ctrl cycle %0d got %b%b", c, bus_wr, bus_size); end
            tick();
        end
        idle();
    endtask

    task automatic test_random();
        logic s, e0wt, e1wt, d0, d1;
        logic [2+2+AW+DW:0] exp_fwd;
        do_reset();
        for (int n = 0; n < 800; n++) begin
            reset = ($urandom_range(0, 99) == 0);
            if (!m0_en && $urandom_range(0, 2) == 0) begin
                m0_en = 1; m0_wr = 1'($urandom_range(0, 1)); m0_size = 2'($urandom_range(0, 3));
                m0_addr = AW'($urandom()); m0_data_out = DW'($urandom());
            end
            if (!m1_en && $urandom_range(0, 2) == 0) begin
                m1_en = 1; m1_wr = 1'($urandom_range(0, 1)); m1_size = 2'($urandom_range(0, 3));
                m1_addr = AW'($urandom()); m1_data_out = DW'($urandom());
            end
            bus_wt = ($urandom_range(0, 2) == 0);
            bus_data_in = DW'($urandom());
            #3;
            s = ref_sel();
            exp_fwd = s ? {m1_en, m1_wr, m1_size, m1_addr, m1_data_out} : {m0_en, m0_wr, m0_size, m0_addr, m0_data_out};
            e0wt = s ? m0_en : bus_wt;
            e1wt = s ? bus_wt : m1_en;
            vectors++; if (owner !== s) begin miscompares++; $display("FAIL rand_owner step %0d got %b want %b", n, owner, s); end
            vectors++; if ({bus_en, bus_wr, bus_size, bus_addr, bus_data_out} !== exp_fwd) begin miscompares++; $display("FAIL rand_fwd step %0d got %h want %h", n, {bus_en, bus_wr, bus_size, bus_addr, bus_data_out}, exp_fwd); end
            vectors++; if ({m0_wt, m1_wt} !== {e0wt, e1wt}) begin miscompares++; $display("FAIL rand_wt step %0d got %b%b want %b%b", n, m0_wt, m1_wt, e0wt, e1wt); end
            vectors++; if ({m0_data_in, m1_data_in} !== {bus_data_in, bus_data_in}) begin miscompares++; $display("FAIL rand_rdata step %0d got %h %h want %h", n, m0_data_in, m1_data_in, bus_data_in); end
            d0 = m0_en && !e0wt;
            d1 = m1_en && !e1wt;
            tick();
            if (d0 || (m0_en && $urandom_range(0, 39) == 0)) m0_en = 0;
            if (d1 || (m1_en && $urandom_range(0, 39) == 0)) m1_en = 0;
        end
        reset = 0; idle(); tick();
    endtask

    initial begin
        reset = 1;
        idle();
        test_reset();
        test_single();
        test_lock_hold();
        test_conflict();
        test_drop();
        test_reset_mid();
        test_wdata_routing();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/busarb2.md
Name: busarb2

Overview:
- Two-master arbiter for the shared system bus in front of the bus controller.
- Master 0 is the CPU. Master 1 is a future bus master (DMA/disk DMA).
- Multiplexes one master at a time onto the single slave-side bus (en/wr/size/addr/data/wt protocol).
- Guarantees a transaction is never switched or interrupted while the slave holds wait.

Parameters:
- AW, 32, address width of master and bus address ports.
- DW, 32, data width of all data ports.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- m0_en  in  1  master 0 request (held until completion)
- m0_wr  in  1  master 0 write
- m0_size  in  2  master 0 access size
- m0_addr  in  AW  master 0 address
- m0_data_out  in  DW  master 0 write data
- m0_data_in  out  DW  read data to master 0
- m0_wt  out  1  wait to master 0
- m1_en, m1_wr, m1_size, m1_addr, m1_data_out, m1_data_in, m1_wt  (same as m0_*, for master 1)
- bus_en  out  1  slave-side enable
- bus_wr  out  1  slave-side write
- bus_size  out  2  slave-side access size
- bus_addr  out  AW  slave-side address
- bus_data_out  out  DW  slave-side write data
- bus_data_in  in  DW  slave-side read data
- bus_wt  in  1  slave-side wait
- owner  out  1  master currently driving the bus (status/debug)

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, port name reset.
- Bus protocol, both sides:
  - A master asserts en and holds en/wr/size/addr/data stable until a cycle with en=1 and wt=0. That cycle completes the transaction.
  - A new transaction may start in the very next cycle.
- State registers:
  - locked (1 bit): 1 = a transaction is in progress.
  - owner (1 bit): which master holds the bus.
  - last (1 bit): master that completed most recently.
- Selection, combinational; sel = selected master:
  - If locked=1: sel=owner.
  - If locked=0 and only one master requests: sel = that master.
  - If locked=0 and both request: winner per arbitration policy (Optional Feature).
  - If locked=0 and no request: sel=owner, bus_en=0.
- Forwarding:
  - bus_en/wr/size/addr/data_out = selected master's signals.
  - bus_en is 1 only if the selected master's en=1.
  - bus_data_in drives both m0_data_in and m1_data_in unconditionally. Masters may only sample it on their completion cycle.
- Wait:
  - Selected master: mX_wt = bus_wt.
  - Non-selected master: mX_wt = mX_en, i.e. 1 while it requests, 0 when idle.
- Zero added latency: a granted request reaches the slave in the same cycle it is raised. A 1-cycle slave therefore completes in 1 cycle.
- Register update each rising clk edge:
  - Selected master has en=1 and bus_wt=1 → locked<=1, owner<=sel.
  - Selected master has en=1 and bus_wt=0 (completion) → locked<=0, owner<=sel, last<=sel.
  - Otherwise no change.
- Locked rule: while locked=1 the other master's request is ignored until completion, even if it is higher priority.
- Ownership handover: at completion with the other master waiting, the other master may be selected in the next cycle. There is no dead cycle between back-to-back transactions of different masters.
- Protocol violation: if the owner drops en while locked=1, locked<=0 in that cycle. bus_en is 0 in that cycle. No transaction is counted.
- Reset values:
  - locked=0, owner=0, last=1.
  - With inputs idle: bus_en=0, m0_wt=0, m1_wt=0.
- Reset mid-transaction: registers return to reset values immediately. Outputs follow the inputs combinationally; the slave is reset concurrently.

Optional Feature:
- Macro: BUSARB_ROUNDROBIN_EN.
- Defined: on a conflict in an unlocked cycle, the winner is the master that is not `last`. Both masters continuously requesting alternate strictly: m0, m1, m0, ...
- Undefined: fixed priority; m1 wins every unlocked conflict. m0 can starve while m1 requests back-to-back. `last` is still maintained but unused for arbitration.

Test Plan:
- Single master, 1-cycle slave: m0 read, addr=0x00000100, bus_wt=0, bus_data_in=0x12345678 → same cycle bus_en=1, bus_addr=0x100, m0_wt=0, m0_data_in=0x12345678. m1_wt=0 throughout.
- Lock hold: m0 write, bus_wt=1 for 3 cycles; m1_en raised in the 2nd cycle → bus_addr stays m0's for all 4 cycles, m1_wt=1. m1 is forwarded in cycle 5, with no gap.
- Conflict after reset, round robin defined: both request each cycle, bus_wt=0 → owner sequence 0,1,0,1 over 4 cycles. Macro undefined → owner 1,1,1,1 and m0_wt=1 throughout.
- Owner drops en while locked (bus_wt=1) → next cycle locked=0. A pending m1 request is granted the following cycle; bus_en=0 in the drop cycle.
- Reset asserted with m1 locked, bus_wt=1 → after the clock edge locked=0, owner=0. With both masters idle: bus_en=0, m0_wt=0, m1_wt=0.
- Write-data routing: m0_data_out=0xAAAA5555, m1_data_out=0x0F0F0F0F, alternating grants → bus_data_out matches the selected master in each cycle.
